mux_sel_rr_arbiter: RTL and testbench
=====================================

// Module: mux_sel_rr_arbiter
// PURPOSE
//   Round-robin arbiter that drives the 2-bit select of the 4:1 mux (mux_4to1) directly downstream.
//   Four requesters raise req; block picks one fairly, presents sel/gnt with valid/ready handshake,
//   holds sel stable for up to BURST accepted beats, then rotates. Registered outputs -> glitch-free sel.
// PARAMETERS
//   N      4   number of requesters (= mux inputs); power of 2, >= 2
//   SELW   $clog2(N)  select width (derived, localparam; 2 for N=4)
//   BURST  4   max accepted beats per grant before forced rotation; >= 1
// PORTS
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   req        in   N     per-requester request, level-sensitive
//   out_ready  in   1     downstream consumer accepts current beat
//   sel        out  SELW  mux select (index of granted requester)
//   gnt        out  N     one-hot grant, gnt[sel] when out_valid, else 0
//   out_valid  out  1     sel/gnt valid; mux output is meaningful
// BEHAVIOUR
//   Reset (async assert, sync release): sel=0, gnt=0, out_valid=0, ptr=N-1, beat_cnt=0, state=IDLE.
//   Pick rule: first set req bit scanning ptr+1, ptr+2, ... mod N (wraps). ptr = last granted index.
//   States: IDLE, GRANT.
//   IDLE: if |req -> register pick into sel, gnt=1<<pick, out_valid=1, beat_cnt=0, -> GRANT (1-cycle latency
//     req->out_valid). If req==0 stay IDLE, outputs hold previous sel, gnt=0, out_valid=0.
//   GRANT, beat accepted (out_valid & out_ready):
//     - beat_cnt==BURST-1 or req[sel]==0: ptr<=sel; if any req other than/including sel via pick from
//       new ptr -> re-grant same edge (back-to-back, no bubble); else -> IDLE, out_valid=0, gnt=0.
//     - otherwise: beat_cnt++, sel held, stay GRANT.
//   GRANT, no accept (out_ready=0): sel, gnt, out_valid, beat_cnt all held, even if req[sel] drops
//     (no retraction once valid).
//   Rotation after burst: only requester => may be re-granted (pick wraps to itself); beat_cnt restarts 0.
//   Simultaneous req changes during accept: pick uses req sampled that same edge.
//   beat_cnt width $clog2(BURST+1); never exceeds BURST-1.
//   Reset mid-GRANT: outputs drop immediately (async), ptr=N-1, so requester 0 has top priority after.
//   Invariants: out_valid==|gnt; gnt==0 or onehot; gnt[sel]==out_valid.
// STRUCTURE
//   Package mux_sel_pkg: typedef enum logic {IDLE, GRANT} arb_state_t; default N, BURST localparams.
//   Sub-module rr_priority_pick (combinational): in req[N], ptr[SELW] -> out any, idx[SELW];
//     rotate-by-(ptr+1), priority-encode, un-rotate. Instanced once; FSM, ptr, beat_cnt in top.
// TESTING (bench drives clk 10ns, instantiates mux_4to1 on sel with in=4'b1010)
//   1 Reset: rst_n=0 mid-GRANT -> sel=0, gnt=0, out_valid=0 same cycle; release, req=4'b0001 -> sel=0 next edge.
//   2 Fairness: req=4'b1111, out_ready=1, BURST=1 -> sel sequence 0,1,2,3,0 on consecutive cycles,
//     mux out 0,1,0,1,0; no idle bubbles.
//   3 Burst: BURST=4, req=4'b0110 held, out_ready=1 -> sel=1 for 4 beats, then sel=2 for 4 beats, then 1.
//   4 Backpressure: grant sel=2, out_ready=0 for 5 cycles, drop req[2] -> sel=2, out_valid=1 held;
//     raise out_ready -> one accept, then IDLE (gnt=0) if req=0.
//   5 Wrap/single requester: ptr=3, req=4'b1000 -> re-granted sel=3 after burst; req=4'b0001 -> sel=0.
//   6 Early release: req[1] drops after 2 accepted beats of BURST=4 -> rotation on 2nd beat accept,
//     next pending requester granted same edge. Assertions for all invariants throughout.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// Shared definitions for the round-robin mux-select arbiter.
//   N_DEFAULT     : default number of requesters (mux inputs)
//   BURST_DEFAULT : default number of accepted beats per grant before rotation
//   arb_state_t   : arbiter FSM state (IDLE = nothing granted, GRANT = sel/gnt valid)
package mux_sel_pkg;

   localparam int N_DEFAULT     = 4;
   localparam int BURST_DEFAULT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick.
// Ports:
//   i_req : per-requester request vector
//   i_ptr : index of the last granted requester (search starts just after it)
//   o_any : at least one request is set
//   o_idx : first set request found scanning i_ptr+1, i_ptr+2, ... modulo N
module rr_priority_pick
   import mux_sel_pkg::*;
#(
   parameter  int N    = N_DEFAULT,
   localparam int SELW = $clog2(N)
) (
   input  logic [N-1:0]    i_req,
   input  logic [SELW-1:0] i_ptr,
   output logic            o_any,
   output logic [SELW-1:0] o_idx
);

   logic [SELW-1:0] w_start;
   logic [N-1:0]    w_rot;
   logic [SELW-1:0] w_off;

   // The scan begins one past the last winner. Because N is a power of two,
   // SELW-bit arithmetic wraps modulo N for free.
   assign w_start = i_ptr + SELW'(1);

   // Rotate the request vector so that position 0 is the highest-priority slot.
   always_comb begin
      w_rot = '0;
      for (int i = 0; i < N; i++) begin
         w_rot[i] = i_req[w_start + SELW'(i)];
      end
   end

   // Priority-encode the rotated vector: scanning downward lets the lowest
   // set bit overwrite any higher one, so the nearest requester wins.
   always_comb begin
      w_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = SELW'(i);
         end
      end
   end

   // Undo the rotation to get back to a real requester index.
   assign o_any = |i_req;
   assign o_idx = w_start + w_off;

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter driving the select of a downstream N:1 mux.
// A grant is held for up to BURST accepted beats (or until the owner drops
// its request on an accepted beat), then the pointer rotates. All outputs
// are registered so the mux select never glitches.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : per-requester level-sensitive request
//   out_ready : downstream accepts the current beat
//   sel       : mux select (index of granted requester)
//   gnt       : one-hot grant, gnt[sel] while out_valid, otherwise zero
//   out_valid : sel/gnt are valid, mux output is meaningful
module mux_sel_rr_arbiter
   import mux_sel_pkg::*;
#(
   parameter  int N     = N_DEFAULT,
   parameter  int BURST = BURST_DEFAULT,
   localparam int SELW  = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            out_ready,
   output logic [SELW-1:0] sel,
   output logic [N-1:0]    gnt,
   output logic            out_valid
);

   localparam int BEATW = $clog2(BURST + 1);

   arb_state_t       r_state;
   logic [SELW-1:0]  r_sel;
   logic [N-1:0]     r_gnt;
   logic             r_valid;
   logic [SELW-1:0]  r_ptr;
   logic [BEATW-1:0] r_beatCnt;

   arb_state_t       w_nextState;
   logic [SELW-1:0]  w_nextSel;
   logic [N-1:0]     w_nextGnt;
   logic             w_nextValid;
   logic [SELW-1:0]  w_nextPtr;
   logic [BEATW-1:0] w_nextBeat;

   logic             w_accept;
   logic             w_lastBeat;
   logic             w_rotate;
   logic [SELW-1:0]  w_pickPtr;
   logic             w_pickAny;
   logic [SELW-1:0]  w_pickIdx;

   // A beat ends the grant when the burst is used up or the owner has let go.
   // The rotation search must start after the current owner, which is exactly
   // what ptr will become, so the picker is fed r_sel directly while granting.
   assign w_accept   = r_valid & out_ready;
   assign w_lastBeat = (r_beatCnt == BEATW'(BURST - 1)) | ~req[r_sel];
   assign w_rotate   = (r_state == GRANT) & w_accept & w_lastBeat;
   assign w_pickPtr  = (r_state == GRANT) ? r_sel : r_ptr;

   rr_priority_pick #(
      .N (N)
   ) u_pick (
      .i_req (req),
      .i_ptr (w_pickPtr),
      .o_any (w_pickAny),
      .o_idx (w_pickIdx)
   );

   // State and datapath registers. Reset puts ptr on the last index so that
   // requester 0 has top priority coming out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_sel     <= '0;
         r_gnt     <= '0;
         r_valid   <= 1'b0;
         r_ptr     <= SELW'(N - 1);
         r_beatCnt <= '0;
      end else begin
         r_state   <= w_nextState;
         r_sel     <= w_nextSel;
         r_gnt     <= w_nextGnt;
         r_valid   <= w_nextValid;
         r_ptr     <= w_nextPtr;
         r_beatCnt <= w_nextBeat;
      end
   end

   // Next-state logic: leave IDLE as soon as anyone asks; leave GRANT only when
   // a rotation finds nobody to hand the mux to.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_pickAny) begin
               w_nextState = GRANT;
            end
         end
         GRANT: begin
            if (w_rotate && !w_pickAny) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Next values of the registered outputs and counters. While backpressured
   // everything holds, even if the owner drops its request: a valid beat is
   // never retracted. On rotation the new winner is loaded on the same edge,
   // so there is no idle bubble between back-to-back grants.
   always_comb begin
      w_nextSel   = r_sel;
      w_nextGnt   = r_gnt;
      w_nextValid = r_valid;
      w_nextPtr   = r_ptr;
      w_nextBeat  = r_beatCnt;
      unique case (r_state)
         IDLE: begin
            w_nextGnt   = '0;
            w_nextValid = 1'b0;
            if (w_pickAny) begin
               w_nextSel   = w_pickIdx;
               w_nextGnt   = {{(N - 1){1'b0}}, 1'b1} << w_pickIdx;
               w_nextValid = 1'b1;
               w_nextBeat  = '0;
            end
         end
         GRANT: begin
            if (w_accept) begin
               if (w_lastBeat) begin
                  w_nextPtr = r_sel;
                  if (w_pickAny) begin
                     w_nextSel   = w_pickIdx;
                     w_nextGnt   = {{(N - 1){1'b0}}, 1'b1} << w_pickIdx;
                     w_nextValid = 1'b1;
                     w_nextBeat  = '0;
                  end else begin
                     w_nextGnt   = '0;
                     w_nextValid = 1'b0;
                     w_nextBeat  = '0;
                  end
               end else begin
                  w_nextBeat = r_beatCnt + BEATW'(1);
               end
            end
         end
         default: begin
            w_nextGnt   = '0;
            w_nextValid = 1'b0;
         end
      endcase
   end

   assign sel       = r_sel;
   assign gnt       = r_gnt;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed testbench for mux_sel_rr_arbiter. Two instances share clock, reset
// and inputs: one with BURST=1 (pure rotation) and one with BURST=4. A 4:1 mux
// with data inputs 4'b1010 is modelled on the BURST=1 select.
module tb_mux_sel_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       outReady;

   logic [1:0] sel1;
   logic [3:0] gnt1;
   logic       valid1;
   logic [1:0] sel4;
   logic [3:0] gnt4;
   logic       valid4;

   logic [3:0] muxIn;
   logic       muxOut1;

   int checks;
   int failures;

   mux_sel_rr_arbiter #(.N(4), .BURST(1)) dutB1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .out_ready (outReady),
      .sel       (sel1),
      .gnt       (gnt1),
      .out_valid (valid1)
   );

   mux_sel_rr_arbiter #(.N(4), .BURST(4)) dutB4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .out_ready (outReady),
      .sel       (sel4),
      .gnt       (gnt4),
      .out_valid (valid4)
   );

   // Downstream 4:1 mux fed by the BURST=1 arbiter's select.
   assign muxIn   = 4'b1010;
   assign muxOut1 = muxIn[sel1];

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, asserts equality, reports on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      assert (actual === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Drive the shared inputs.
   task automatic applyStimulus(input logic [3:0] r, input logic rdy);
      req      = r;
      outReady = rdy;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset for one cycle with inputs idle.
   task automatic doReset();
      applyStimulus(4'b0000, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Structural invariants on both instances, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("inv_valid_b1", 32'(valid1), 32'(|gnt1));
         checkOutput("inv_onehot_b1", 32'($onehot0(gnt1)), 32'd1);
         checkOutput("inv_gntsel_b1", 32'(gnt1[sel1]), 32'(valid1));
         checkOutput("inv_valid_b4", 32'(valid4), 32'(|gnt4));
         checkOutput("inv_onehot_b4", 32'($onehot0(gnt4)), 32'd1);
         checkOutput("inv_gntsel_b4", 32'(gnt4[sel4]), 32'(valid4));
      end
   end

   logic [1:0] expFairSel1 [5];
   logic       expFairMux  [5];
   logic [1:0] expFairSel4 [5];
   logic [1:0] expBurstSel [9];

   initial begin
      checks   = 0;
      failures = 0;
      expFairSel1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      expFairMux  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      expFairSel4 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
      expBurstSel = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

      rst_n = 1'b0;
      applyStimulus(4'b0000, 1'b0);
      tick();
      tick();

      $display("[TB] reset values");
      checkOutput("rst_sel_b1", 32'(sel1), 32'd0);
      checkOutput("rst_gnt_b1", 32'(gnt1), 32'd0);
      checkOutput("rst_valid_b1", 32'(valid1), 32'd0);
      checkOutput("rst_sel_b4", 32'(sel4), 32'd0);
      checkOutput("rst_gnt_b4", 32'(gnt4), 32'd0);
      checkOutput("rst_valid_b4", 32'(valid4), 32'd0);
      rst_n = 1'b1;

      // All four requesting with ready high: BURST=1 rotates every cycle.
      $display("[TB] fairness");
      applyStimulus(4'b1111, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("fair_sel_b1_%0d", i), 32'(sel1), 32'(expFairSel1[i]));
         checkOutput($sformatf("fair_valid_b1_%0d", i), 32'(valid1), 32'd1);
         checkOutput($sformatf("fair_mux_%0d", i), 32'(muxOut1), 32'(expFairMux[i]));
         checkOutput($sformatf("fair_sel_b4_%0d", i), 32'(sel4), 32'(expFairSel4[i]));
      end

      // Two requesters with BURST=4: four beats each, alternating.
      $display("[TB] burst");
      doReset();
      applyStimulus(4'b0110, 1'b1);
      for (int i = 0; i < 9; i++) begin
         tick();
         checkOutput($sformatf("burst_sel_%0d", i), 32'(sel4), 32'(expBurstSel[i]));
         checkOutput($sformatf("burst_valid_%0d", i), 32'(valid4), 32'd1);
      end

      // Asynchronous reset while granting: outputs drop without a clock edge.
      $display("[TB] async reset mid-grant");
      rst_n = 1'b0;
      #1;
      checkOutput("arst_sel", 32'(sel4), 32'd0);
      checkOutput("arst_gnt", 32'(gnt4), 32'd0);
      checkOutput("arst_valid", 32'(valid4), 32'd0);
      applyStimulus(4'b0001, 1'b0);
      rst_n = 1'b1;
      tick();
      checkOutput("arst_regrant_sel", 32'(sel4), 32'd0);
      checkOutput("arst_regrant_gnt", 32'(gnt4), 32'h1);
      checkOutput("arst_regrant_valid", 32'(valid4), 32'd1);

      // Backpressure: grant is held even after the owner drops its request.
      $display("[TB] backpressure");
      doReset();
      applyStimulus(4'b0100, 1'b0);
      tick();
      checkOutput("bp_sel", 32'(sel4), 32'd2);
      checkOutput("bp_gnt", 32'(gnt4), 32'h4);
      applyStimulus(4'b0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("bp_hold_sel_%0d", i), 32'(sel4), 32'd2);
         checkOutput($sformatf("bp_hold_valid_%0d", i), 32'(valid4), 32'd1);
      end
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkOutput("bp_release_valid", 32'(valid4), 32'd0);
      checkOutput("bp_release_gnt", 32'(gnt4), 32'h0);
      checkOutput("bp_release_sel", 32'(sel4), 32'd2);
      tick();
      checkOutput("bp_idle_valid", 32'(valid4), 32'd0);

      // Single requester on the last index is re-granted after its burst.
      $display("[TB] wrap");
      doReset();
      applyStimulus(4'b1000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("wrap_sel_%0d", i), 32'(sel4), 32'd3);
         checkOutput($sformatf("wrap_valid_%0d", i), 32'(valid4), 32'd1);
      end
      applyStimulus(4'b0001, 1'b1);
      tick();
      checkOutput("wrap_next_sel", 32'(sel4), 32'd0);
      checkOutput("wrap_next_gnt", 32'(gnt4), 32'h1);

      // Owner releases early: rotation on its second accepted beat.
      $display("[TB] early release");
      doReset();
      applyStimulus(4'b1010, 1'b1);
      tick();
      checkOutput("early_first_sel", 32'(sel4), 32'd1);
      tick();
      checkOutput("early_beat1_sel", 32'(sel4), 32'd1);
      applyStimulus(4'b1000, 1'b1);
      tick();
      checkOutput("early_rot_sel", 32'(sel4), 32'd3);
      checkOutput("early_rot_gnt", 32'(gnt4), 32'h8);
      checkOutput("early_rot_valid", 32'(valid4), 32'd1);

      applyStimulus(4'b0000, 1'b0);
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
